// File: rtl/prime_bus_master.sv
// Bus initiator for the prime-number peripheral: writes N to the argument
// register, polls status until DONE, reads the result word and returns the
// unpacked prime and found-counter on a single-cycle response port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a request, req_ready high
// WR      | write transaction: N to the argument register
// POLL    | read transaction: status register, counts polls
// GAP     | idle spacing between consecutive status reads
// RD      | read transaction: result register, unpack prime/count
// RESP    | resp_valid pulse for one cycle
//
// Every bus transaction runs SETUP (1) -> STROBE (STROBE_CYCLES) -> HOLD (1).
module prime_bus_master #(
   parameter int          STROBE_CYCLES = 2,
   parameter int          POLL_GAP      = 4,
   parameter int          MAX_POLLS     = 65535,
   parameter int          N_MAX         = 1000,
   parameter logic [15:0] ADDR_A        = 16'h00EC,
   parameter logic [15:0] ADDR_S        = 16'h0104,
   parameter logic [15:0] ADDR_W        = 16'h00FC,
   parameter int          DONE_CODE     = 5
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        req_valid,
   input  logic [9:0]  req_n,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [12:0] resp_prime,
   output logic [3:0]  resp_count,
   output logic        resp_err,
   output logic        busy,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] sdata_in,
   input  logic [31:0] sdata_out
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR, ST_POLL, ST_GAP, ST_RD, ST_RESP
   } state_t;

   typedef enum logic [1:0] {
      PH_SETUP, PH_STROBE, PH_HOLD
   } phase_t;

   localparam logic [15:0] STROBE_LD  = 16'(STROBE_CYCLES - 1);
   localparam logic [15:0] GAP_LD     = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;
   localparam logic [15:0] POLL_LIMIT = 16'(MAX_POLLS);
   localparam logic [9:0]  N_LIMIT    = 10'(N_MAX);
   localparam logic [2:0]  DONE_VAL   = 3'(DONE_CODE);

   state_t      state, state_nxt;
   phase_t      phase, phase_nxt;
   logic [15:0] tmr, tmr_nxt;
   logic [15:0] poll_cnt;
   logic [15:0] poll_inc;
   logic [9:0]  n_lat;
   logic        started;
   logic        accept;
   logic        n_bad;
   logic        status_done;
   logic [12:0] rd_prime;
   logic        unused_bits;

   assign accept      = req_valid && req_ready;
   assign n_bad       = (req_n == 10'd0) || (req_n > N_LIMIT);
   assign poll_inc    = poll_cnt + 16'd1;
   assign status_done = (sdata_out[2:0] == DONE_VAL);
   assign rd_prime    = sdata_out[16:4];
   assign unused_bits = ^sdata_out[31:17];

   // State, transaction phase and down-counter registers
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= ST_IDLE;
         phase <= PH_SETUP;
         tmr   <= 16'd0;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
         tmr   <= tmr_nxt;
      end
   end

   // Next-state logic; transactions advance on the phase, GAP on the timer
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      tmr_nxt   = tmr;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = n_bad ? ST_RESP : ST_WR;
               phase_nxt = PH_SETUP;
            end
         end
         ST_WR, ST_POLL, ST_RD: begin
            case (phase)
               PH_SETUP: begin
                  phase_nxt = PH_STROBE;
                  tmr_nxt   = STROBE_LD;
               end
               PH_STROBE: begin
                  if (tmr == 16'd0) phase_nxt = PH_HOLD;
                  else              tmr_nxt   = tmr - 16'd1;
               end
               default: begin
                  phase_nxt = PH_SETUP;
                  if (state == ST_WR)                state_nxt = ST_POLL;
                  else if (state == ST_RD)           state_nxt = ST_RESP;
                  else if (status_done)              state_nxt = ST_RD;
                  else if (poll_inc == POLL_LIMIT)   state_nxt = ST_RESP;
                  else if (POLL_GAP == 0)            state_nxt = ST_POLL;
                  else begin
                     state_nxt = ST_GAP;
                     tmr_nxt   = GAP_LD;
                  end
               end
            endcase
         end
         ST_GAP: begin
            if (tmr == 16'd0) state_nxt = ST_POLL;
            else              tmr_nxt   = tmr - 16'd1;
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Bus and handshake outputs decoded from state/phase so reset drops them at once
   always_comb begin
      saddress   = 16'd0;
      sdata_in   = 32'd0;
      srd        = 1'b0;
      swr        = 1'b0;
      req_ready  = (state == ST_IDLE) && started;
      resp_valid = (state == ST_RESP);
      busy       = (state != ST_IDLE);
      case (state)
         ST_WR: begin
            saddress = ADDR_A;
            sdata_in = {22'd0, n_lat};
            swr      = (phase == PH_STROBE);
         end
         ST_POLL: begin
            saddress = ADDR_S;
            srd      = (phase == PH_STROBE);
         end
         ST_RD: begin
            saddress = ADDR_W;
            srd      = (phase == PH_STROBE);
         end
         default: ;
      endcase
   end

   // Request latch, poll counter and response registers
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         started    <= 1'b0;
         n_lat      <= 10'd0;
         poll_cnt   <= 16'd0;
         resp_prime <= 13'd0;
         resp_count <= 4'd0;
         resp_err   <= 1'b0;
      end else begin
         started <= 1'b1;
         if (state == ST_IDLE && accept) begin
            n_lat    <= req_n;
            poll_cnt <= 16'd0;
            if (n_bad) begin
               resp_prime <= 13'd0;
               resp_count <= 4'd0;
               resp_err   <= 1'b1;
            end
         end
         if (state == ST_POLL && phase == PH_HOLD) begin
            poll_cnt <= poll_inc;
            if (!status_done && poll_inc == POLL_LIMIT) begin
               resp_prime <= 13'd0;
               resp_count <= 4'd0;
               resp_err   <= 1'b1;
            end
         end
         if (state == ST_RD && phase == PH_HOLD) begin
            resp_prime <= rd_prime;
            resp_count <= sdata_out[3:0];
            resp_err   <= (rd_prime == 13'd0);
         end
      end
   end

endmodule

// File: tb/tb_prime_bus_master.sv
// Testbench for prime_bus_master with a behavioural prime peripheral and
// stub modes (stuck status, zero result). Bus protocol is checked every cycle.
module tb_prime_bus_master;

   localparam int          STROBE_CYCLES = 2;
   localparam int          POLL_GAP      = 4;
   localparam int          MAX_POLLS     = 8;
   localparam logic [15:0] ADDR_A        = 16'h00EC;
   localparam logic [15:0] ADDR_S        = 16'h0104;
   localparam logic [15:0] ADDR_W        = 16'h00FC;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        req_valid = 1'b0;
   logic [9:0]  req_n = 10'd0;
   logic        req_ready;
   logic        resp_valid;
   logic [12:0] resp_prime;
   logic [3:0]  resp_count;
   logic        resp_err;
   logic        busy;
   logic [15:0] saddress;
   logic        srd;
   logic        swr;
   logic [31:0] sdata_in;
   logic [31:0] sdata_out = 32'd0;

   prime_bus_master #(
      .STROBE_CYCLES(STROBE_CYCLES),
      .POLL_GAP(POLL_GAP),
      .MAX_POLLS(MAX_POLLS)
   ) dut (
      .clk(clk),
      .n_reset(n_reset),
      .req_valid(req_valid),
      .req_n(req_n),
      .req_ready(req_ready),
      .resp_valid(resp_valid),
      .resp_prime(resp_prime),
      .resp_count(resp_count),
      .resp_err(resp_err),
      .busy(busy),
      .saddress(saddress),
      .srd(srd),
      .swr(swr),
      .sdata_in(sdata_in),
      .sdata_out(sdata_out)
   );

   always #5 clk = ~clk;

   // ---------------- peripheral model ----------------
   // mode 0: real prime engine, 1: status stuck at 1, 2: DONE but W reads 0
   int          mode = 0;
   logic        p_srd_q = 1'b0;
   logic        p_swr_q = 1'b0;
   logic [9:0]  p_n = 10'd0;
   logic        p_done = 1'b1;
   int          p_delay = 0;
   logic [3:0]  p_found = 4'd0;
   logic [12:0] p_prime = 13'd0;

   function automatic logic is_prime(input int k);
      if (k < 2) return 1'b0;
      for (int d = 2; d * d <= k; d++)
         if (k % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int nth_prime(input int n);
      int c = 0;
      int k = 1;
      while (c < n) begin
         k++;
         if (is_prime(k)) c++;
      end
      return k;
   endfunction

   always @(posedge clk) begin
      p_srd_q <= srd;
      p_swr_q <= swr;
      if (swr && !p_swr_q && saddress == ADDR_A) begin
         p_n     <= sdata_in[9:0];
         p_done  <= 1'b0;
         p_delay <= 5 + int'(sdata_in[9:0]) / 100;
      end else if (!p_done && p_delay == 0) begin
         p_done  <= 1'b1;
         p_found <= p_found + 4'd1;
         p_prime <= 13'(nth_prime(int'(p_n)));
      end else if (!p_done) begin
         p_delay <= p_delay - 1;
      end
      if (srd && !p_srd_q) begin
         if (saddress == ADDR_S)
            sdata_out <= (mode == 1) ? 32'd1 : (mode == 2) ? 32'd5 : (p_done ? 32'd5 : 32'd1);
         else if (saddress == ADDR_W)
            sdata_out <= (mode == 2) ? 32'd0 : {15'd0, p_prime, p_found};
         else
            sdata_out <= 32'hDEAD_BEEF;
      end
   end

   // ---------------- bench state ----------------
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic        prev_srd = 1'b0;
   logic        prev_swr = 1'b0;
   logic [15:0] prev_addr = 16'd0;
   int          width = 0;
   int          cnt_wr_a = 0;
   int          cnt_rd_s = 0;
   int          cnt_rd_w = 0;
   int          cnt_other = 0;
   logic [31:0] last_wdata = 32'd0;
   int          t_wr_rise = 0;
   int          t_s_rise = -1;

   // Advance to the next falling edge and check the bus protocol there
   task automatic tick();
      int gap_exp;
      int gap_obs;
      @(negedge clk);
      cyc++;
      if (!n_reset) begin
         prev_srd  = 1'b0;
         prev_swr  = 1'b0;
         prev_addr = saddress;
         width     = 0;
         return;
      end
      n_checks++;
      if (srd && swr) begin
         n_fail++;
         $display("FAIL strobe_overlap: srd=%b swr=%b, required not both high", srd, swr);
      end
      if (srd || swr) begin
         if (!(prev_srd || prev_swr)) begin
            n_checks++;
            if (saddress !== prev_addr) begin
               n_fail++;
               $display("FAIL setup_addr: addr %h at strobe rise, required %h from setup cycle", saddress, prev_addr);
            end
            width = 1;
            if (swr) begin
               if (saddress == ADDR_A) cnt_wr_a++; else cnt_other++;
               last_wdata = sdata_in;
               t_wr_rise  = cyc;
               t_s_rise   = -1;
            end else if (saddress == ADDR_S) begin
               cnt_rd_s++;
               gap_exp = (t_s_rise < 0) ? (STROBE_CYCLES + 2) : (STROBE_CYCLES + 2 + POLL_GAP);
               gap_obs = (t_s_rise < 0) ? (cyc - t_wr_rise) : (cyc - t_s_rise);
               n_checks++;
               if (gap_obs != gap_exp) begin
                  n_fail++;
                  $display("FAIL poll_spacing: %0d cycles between strobe rises, required %0d", gap_obs, gap_exp);
               end
               t_s_rise = cyc;
            end else if (saddress == ADDR_W) begin
               cnt_rd_w++;
            end else begin
               cnt_other++;
            end
         end else begin
            width++;
            n_checks++;
            if (saddress !== prev_addr) begin
               n_fail++;
               $display("FAIL addr_stable: addr %h during strobe, required %h", saddress, prev_addr);
            end
         end
      end else if (prev_srd || prev_swr) begin
         n_checks++;
         if (width != STROBE_CYCLES) begin
            n_fail++;
            $display("FAIL strobe_width: %0d cycles, required %0d", width, STROBE_CYCLES);
         end
      end
      prev_srd  = srd;
      prev_swr  = swr;
      prev_addr = saddress;
   endtask

   // Issue one request from a falling edge; returns cycles from the accepting edge to resp_valid
   task automatic run_req(input logic [9:0] n, output int lat);
      cnt_wr_a = 0; cnt_rd_s = 0; cnt_rd_w = 0; cnt_other = 0;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL req_ready_idle: req_ready=%b, required 1", req_ready);
      end
      req_valid = 1'b1;
      req_n     = n;
      tick();
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 3000) begin
         n_checks++;
         if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_busy: req_ready=%b busy=%b, required 0/1", req_ready, busy);
         end
         tick();
         lat++;
      end
      n_checks++;
      if (resp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL resp_timeout: no resp_valid after %0d cycles, required a response", lat);
      end
      tick();
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL resp_pulse: resp_valid=%b req_ready=%b one cycle later, required 0/1", resp_valid, req_ready);
      end
   endtask

   task automatic check_resp(input string name, input logic [12:0] prime, input logic [3:0] count,
                             input logic err, input logic chk_count);
      n_checks++;
      if (resp_prime !== prime || resp_err !== err || (chk_count && resp_count !== count)) begin
         n_fail++;
         $display("FAIL %s: prime=%0d count=%0d err=%b, required prime=%0d count=%0d err=%b",
                  name, resp_prime, resp_count, resp_err, prime, count, err);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (srd !== 1'b0 || swr !== 1'b0 || saddress !== 16'd0 || sdata_in !== 32'd0 ||
          req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_prime !== 13'd0 ||
          resp_count !== 4'd0 || resp_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: srd=%b swr=%b addr=%h wd=%h rdy=%b rv=%b p=%0d c=%0d e=%b busy=%b, required all 0",
                  name, srd, swr, saddress, sdata_in, req_ready, resp_valid, resp_prime, resp_count, resp_err, busy);
      end
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      tick();
      tick();
      check_reset_outputs("reset_values");
      n_reset = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_after_release: req_ready=%b before first clk, required 0", req_ready);
      end
      tick();
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_first_clk: req_ready=%b, required 1", req_ready);
      end
   endtask

   task automatic test_single();
      int lat;
      mode = 0;
      run_req(10'd1, lat);
      check_resp("n1_result", 13'd2, 4'd1, 1'b0, 1'b1);
      n_checks++;
      if (cnt_wr_a != 1 || last_wdata !== 32'd1 || cnt_rd_w != 1 || cnt_rd_s < 1 || cnt_other != 0) begin
         n_fail++;
         $display("FAIL n1_bus: wrA=%0d wdata=%0d rdS=%0d rdW=%0d other=%0d, required 1/1/>=1/1/0",
                  cnt_wr_a, last_wdata, cnt_rd_s, cnt_rd_w, cnt_other);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      mode = 0;
      run_req(10'd10, lat);
      check_resp("n10_result", 13'd29, 4'd2, 1'b0, 1'b1);
      run_req(10'd1000, lat);
      check_resp("n1000_result", 13'd7919, 4'd3, 1'b0, 1'b1);
      n_checks++;
      if (last_wdata !== 32'd1000) begin
         n_fail++;
         $display("FAIL n1000_wdata: %0d, required 1000", last_wdata);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int guard;
      mode = 0;
      req_valid = 1'b1;
      req_n     = 10'd50;
      tick();
      req_valid = 1'b0;
      guard = 0;
      while (!(srd === 1'b1 && saddress == ADDR_S) && guard < 200) begin
         tick();
         guard++;
      end
      n_checks++;
      if (!(srd === 1'b1 && saddress == ADDR_S)) begin
         n_fail++;
         $display("FAIL poll_strobe_seen: srd=%b addr=%h, required srd=1 at %h", srd, saddress, ADDR_S);
      end
      n_reset = 1'b0;
      #1;
      check_reset_outputs("reset_mid_strobe");
      tick();
      tick();
      n_reset = 1'b1;
      tick();
      run_req(10'd3, lat);
      check_resp("n3_after_reset", 13'd5, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic test_illegal();
      int lat;
      logic [9:0] bad [2];
      bad[0] = 10'd0;
      bad[1] = 10'd1001;
      for (int i = 0; i < 2; i++) begin
         run_req(bad[i], lat);
         check_resp("illegal_result", 13'd0, 4'd0, 1'b1, 1'b1);
         n_checks++;
         if (lat != 1 || cnt_wr_a != 0 || cnt_rd_s != 0 || cnt_rd_w != 0 || cnt_other != 0) begin
            n_fail++;
            $display("FAIL illegal_n%0d: lat=%0d strobes=%0d/%0d/%0d/%0d, required lat=1 no strobes",
                     bad[i], lat, cnt_wr_a, cnt_rd_s, cnt_rd_w, cnt_other);
         end
      end
   endtask

   task automatic test_timeout();
      int lat;
      mode = 1;
      run_req(10'd5, lat);
      check_resp("timeout_result", 13'd0, 4'd0, 1'b1, 1'b1);
      n_checks++;
      if (cnt_rd_s != MAX_POLLS || cnt_rd_w != 0 || cnt_wr_a != 1) begin
         n_fail++;
         $display("FAIL timeout_polls: rdS=%0d rdW=%0d wrA=%0d, required %0d/0/1",
                  cnt_rd_s, cnt_rd_w, cnt_wr_a, MAX_POLLS);
      end
   endtask

   task automatic test_zero_result();
      int lat;
      mode = 2;
      run_req(10'd7, lat);
      check_resp("zero_result", 13'd0, 4'd0, 1'b1, 1'b1);
      n_checks++;
      if (lat != 13 || cnt_rd_s != 1 || cnt_rd_w != 1) begin
         n_fail++;
         $display("FAIL best_latency: lat=%0d rdS=%0d rdW=%0d, required 13/1/1", lat, cnt_rd_s, cnt_rd_w);
      end
      mode = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid();
      test_illegal();
      test_timeout();
      test_zero_result();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
